// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer. Locks to a sync marker, tracks slot and bit index,
// and assembles one WIDTH-bit word per channel, MSB first.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic             in_bit,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [3:0]       o_valid,
    output logic             sync_err
);

    // state  | meaning
    // HUNT   | waiting for the first sync beat, data discarded
    // LOCKED | aligned; slot/bidx track the stream, flywheel across missing syncs
    typedef enum logic {HUNT, LOCKED} state_t;

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t state, state_next;

    logic [1:0]       slot;
    logic [BW-1:0]    bidx;
    logic [WIDTH-2:0] sh     [4];
    logic [WIDTH-1:0] o_word [4];
    logic [WIDTH-1:0] word_in;

    logic take_first;
    logic misalign;
    logic normal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (in_valid && in_sync) state_next = LOCKED;
            LOCKED:  state_next = LOCKED;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        locked     = (state == LOCKED);
        take_first = 1'b0;
        misalign   = 1'b0;
        normal     = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: take_first = in_sync;
                LOCKED: begin
                    if (in_sync && (slot != 2'd0 || bidx != '0)) begin
                        misalign = 1'b1;
                    end else begin
                        normal = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign word_in = {sh[slot], in_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= 2'd0;
            bidx     <= '0;
            o_valid  <= 4'd0;
            sync_err <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                sh[k]     <= '0;
                o_word[k] <= '0;
            end
        end else begin
            o_valid  <= 4'd0;
            sync_err <= misalign;
            if (take_first || misalign) begin
                // Partial words are dropped; this beat restarts the frame as ch0, bit 0.
                for (int k = 1; k < 4; k++) begin
                    sh[k] <= '0;
                end
                sh[0] <= (WIDTH-1)'(in_bit);
                slot  <= 2'd1;
                bidx  <= '0;
            end else if (normal) begin
                sh[slot] <= word_in[WIDTH-2:0];
                if (bidx == LAST) begin
                    o_word[slot]  <= word_in;
                    o_valid[slot] <= 1'b1;
                end
                slot <= slot + 2'd1;
                if (slot == 2'd3) begin
                    bidx <= (bidx == LAST) ? '0 : bidx + 1'b1;
                end
            end
        end
    end

    assign s1 = slot[1];
    assign s0 = slot[0];
    assign o0 = o_word[0];
    assign o1 = o_word[1];
    assign o2 = o_word[2];
    assign o3 = o_word[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-position reference model predicts completions
// and sync errors; a negedge monitor pops and compares whatever the DUT presents.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sync = 1'b0;
    logic         in_bit = 1'b0;
    logic         s1, s0, locked, sync_err;
    logic [W-1:0] o0, o1, o2, o3;
    logic [3:0]   o_valid;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .in_bit(in_bit),
        .s1(s1), .s0(s0), .locked(locked),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .o_valid(o_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ch;
        logic [W-1:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: one position counter over the whole 4*W-beat frame.
    bit           m_locked;
    int           m_pos;
    logic [W-1:0] m_acc [4];
    logic [W-1:0] m_out [4];

    function automatic logic [W-1:0] dut_word(input int ch);
        case (ch)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return o3;
        endcase
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = '0;
            m_out[k] = '0;
        end
    endtask

    task automatic model_beat(input bit sy, input bit b);
        int   ch, bi;
        exp_t e;
        if (!m_locked) begin
            if (!sy) return;
            m_locked = 1'b1;
            m_pos    = 0;
        end else if (sy && m_pos != 0) begin
            err_q.push_back(m_pos);
            m_pos = 0;
        end
        ch = m_pos % 4;
        bi = m_pos / 4;
        m_acc[ch][W-1-bi] = b;
        if (bi == W - 1) begin
            m_out[ch] = m_acc[ch];
            e.ch   = ch;
            e.word = m_acc[ch];
            exp_q.push_back(e);
        end
        m_pos = (m_pos + 1) % (4 * W);
    endtask

    task automatic check_state();
        logic [1:0] s_exp;
        s_exp = m_locked ? 2'(m_pos % 4) : 2'd0;
        checks++;
        if ({s1, s0} !== s_exp) begin
            errors++;
            $display("FAIL slot at %0t: got %b want %b", $time, {s1, s0}, s_exp);
        end
        checks++;
        if (locked !== m_locked) begin
            errors++;
            $display("FAIL locked at %0t: got %b want %b", $time, locked, m_locked);
        end
        checks++;
        if (o0 !== m_out[0] || o1 !== m_out[1] || o2 !== m_out[2] || o3 !== m_out[3]) begin
            errors++;
            $display("FAIL held_words at %0t: got %h %h %h %h want %h %h %h %h", $time,
                     o0, o1, o2, o3, m_out[0], m_out[1], m_out[2], m_out[3]);
        end
    endtask

    task automatic beat(input bit sy, input bit b);
        in_valid = 1'b1;
        in_sync  = sy;
        in_bit   = b;
        model_beat(sy, b);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_sync  = 1'($urandom);
            in_bit   = 1'($urandom);
            @(posedge clk);
            #1;
            check_state();
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sync  = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check_state();
        checks++;
        if (o_valid !== 4'd0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got o_valid=%b sync_err=%b want 0000 0", o_valid, sync_err);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] w3,
                              input bit sy, input int gap_at, input int gap_len);
        logic [W-1:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int b = 0; b < W; b++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (b * 4 + ch == gap_at) idle(gap_len);
                beat(sy && b == 0 && ch == 0, w[ch][W-1-b]);
            end
        end
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (o_valid != 4'd0) begin
            pulses += $countones(o_valid);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid at %0t: got o_valid=%b want none", $time, o_valid);
            end else begin
                m_e = exp_q.pop_front();
                if (o_valid !== 4'(1 << m_e.ch) || dut_word(m_e.ch) !== m_e.word) begin
                    errors++;
                    $display("FAIL completion at %0t: got o_valid=%b word=%h want o_valid=%b word=%h",
                             $time, o_valid, dut_word(m_e.ch), 4'(1 << m_e.ch), m_e.word);
                end
            end
        end
        if (sync_err === 1'b1) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sync_err at %0t: got 1 want 0", $time);
            end else begin
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        model_reset();
        do_reset();
        do_reset();

        // Hunt: no sync, nothing should happen
        for (int i = 0; i < 10; i++) beat(1'b0, 1'($urandom));

        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, -1, 0);
        settle();

        // Flywheel: second frame without sync, 3-cycle gap before slot 2 of bit index 4
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, -1, 0);
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 4 * 4 + 2, 3);
        settle();

        // Misaligned sync at slot 2, bit index 3
        partial(3 * 4 + 2);
        send_frame(8'hC3, 8'h5A, 8'h0F, 8'hF0, 1'b1, -1, 0);
        settle();

        // Reset at slot 1, bit index 5, then relock
        partial(5 * 4 + 1);
        do_reset();
        partial(4);
        send_frame(8'h9E, 8'h61, 8'h80, 8'h7F, 1'b1, -1, 0);
        settle();

        // Wrap-around: three frames with sync every frame
        p0 = pulses;
        for (int f = 0; f < 3; f++)
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 9, f);
        settle();
        checks++;
        if (pulses - p0 != 12) begin
            errors++;
            $display("FAIL wrap_pulse_count: got %0d want 12", pulses - p0);
        end

        // Random stream with gaps, occasional syncs and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(299, 0) == 0) do_reset();
            else if ($urandom_range(3, 0) == 0) idle(1);
            else beat($urandom_range(39, 0) == 0 || (i % 97 == 0), 1'($urandom));
        end
        idle(2);
        settle();

        checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d words %0d sync errors pending want 0 0",
                     exp_q.size(), err_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
